datapath_param: RTL

//  Next-generation parametrised datapath: register file, ALU, local RAM, status register.

---
 rtl/datapath_param.sv | 105 ++++++++++
 1 files changed

// File: rtl/datapath_param.sv
// datapath_param: register file, ALU, status register and a local RAM behind a multi-cycle req/busy/done sequencer
module datapath_param #(
  parameter int W       = 64,
  parameter int NREG    = 8,
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             k,
  input  logic [$clog2(NREG)-1:0]  reg_addr,
  input  logic [$clog2(NREG)-1:0]  a_addr,
  input  logic [$clog2(NREG)-1:0]  b_addr,
  input  logic [3:0]               fs,
  input  logic                     c0,
  input  logic                     b_sel,
  input  logic [1:0]               d_sel,
  input  logic                     reg_w,
  input  logic                     stat_en,
  input  logic                     mem_req,
  input  logic                     mem_we,
  output logic [4:0]               status,
  output logic [W-1:0]             d_out,
  output logic                     mem_busy,
  output logic                     mem_done,
  output logic                     req_drop
);
  localparam int MAW = $clog2(DEPTH);
  localparam int SW  = $clog2(W);
  localparam int CW  = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t         state;
  logic [W-1:0]   rf [NREG];
  logic [W-1:0]   ram [DEPTH];
  logic [W-1:0]   data_a, data_b, op_b, ob, f, rdata, wdata_q;
  logic [W:0]     sum;
  logic [MAW-1:0] addr_q;
  logic [CW-1:0]  cnt;
  logic [3:0]     stat_q;
  logic           we_q, arith, cout, v, z, last;
  assign data_a = (ZERO_R0 != 0 && a_addr == '0) ? '0 : rf[a_addr];
  assign data_b = (ZERO_R0 != 0 && b_addr == '0) ? '0 : rf[b_addr];
  assign op_b   = b_sel ? k : data_b;
  assign arith  = fs == 4'd4 || fs == 4'd5;
  assign ob     = fs == 4'd5 ? ~op_b : op_b;
  assign sum    = {1'b0, data_a} + {1'b0, ob} + {{W{1'b0}}, fs == 4'd5 ? 1'b1 : c0};
  always_comb begin
    f = '0;
    case (fs)
      4'd0:       f = data_a & op_b;
      4'd1:       f = data_a | op_b;
      4'd2:       f = data_a ^ op_b;
      4'd3:       f = ~data_a;
      4'd4, 4'd5: f = sum[W-1:0];
      4'd6:       f = data_a << op_b[SW-1:0];
      4'd7:       f = data_a >> op_b[SW-1:0];
      4'd8:       f = op_b;
      default:    f = '0;
    endcase
  end
  // subtraction runs as A + ~B + 1, so overflow compares A against the inverted operand
  assign cout     = arith & sum[W];
  assign v        = arith & (data_a[W-1] == ob[W-1]) & (f[W-1] != data_a[W-1]);
  assign z        = f == '0;
  assign status   = {stat_q, z};
  assign d_out    = d_sel == 2'b00 ? k : d_sel == 2'b01 ? data_b : d_sel == 2'b10 ? f : rdata;
  assign mem_busy = state == BUSY;
  assign last     = mem_busy && cnt == CW'(MEM_LAT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    else if (reg_w && !(d_sel == 2'b11 && mem_busy) && !(ZERO_R0 != 0 && reg_addr == '0))
      rf[reg_addr] <= d_out;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata    <= '0;
      mem_done <= 1'b0;
      req_drop <= 1'b0;
      stat_q   <= '0;
    end else begin
      mem_done <= last;
      if (stat_en) stat_q <= {v, cout, f[W-1], z};
      if (mem_req && mem_busy) req_drop <= 1'b1;
      if (state == IDLE && mem_req) begin
        state   <= BUSY;
        cnt     <= '0;
        addr_q  <= data_a[MAW-1:0];
        wdata_q <= data_b;
        we_q    <= mem_we;
      end else if (last) begin
        state <= IDLE;
        if (!we_q) rdata <= ram[addr_q];
      end else if (mem_busy)
        cnt <= cnt + CW'(1);
    end
  // RAM is not reset; an aborted access never reaches its last cycle, so it never commits
  always_ff @(posedge clk)
    if (last && we_q) ram[addr_q] <= wdata_q;
endmodule
